// File: rtl/mul16_seq_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier controller.
// Optional MUL16_SIGNED_EN build macro is consumed by mul16_seq_ctrl.
package mul16_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PP0,
        ST_PP1,
        ST_PP2,
        ST_PP3,
        ST_DONE
    } state_t;

    // Bit n selects the high byte of the operand for partial product n.
    localparam logic [3:0] A_HI = 4'b1010;
    localparam logic [3:0] B_HI = 4'b1100;

    localparam int unsigned SH0 = 0;
    localparam int unsigned SH1 = 8;
    localparam int unsigned SH2 = 8;
    localparam int unsigned SH3 = 16;

    function automatic logic [7:0] sel_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

    function automatic logic [1:0] pp_index(input state_t s);
        case (s)
            ST_PP1:  return 2'd1;
            ST_PP2:  return 2'd2;
            ST_PP3:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mul16_seq_ctrl_array8.sv
// Combinational 8x8 unsigned array multiplier: sum of AND-gated shifted rows.
module array8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + (16'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Multi-cycle 16x16->32 multiplier sequencing four byte products through one array8.
// Define MUL16_SIGNED_EN for two's complement operands (sign-magnitude internally).
module mul16_seq_ctrl
    import mul16_seq_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic [15:0] pp;
    logic [31:0] acc;
    logic [31:0] pp_shifted;
    logic [31:0] acc_next;
    logic [31:0] result;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic [1:0]  idx;
    logic [1:0]  nidx;
    logic        zero_op;

    array8 u_array8 (
        .a (mul_x),
        .b (mul_y),
        .p (pp)
    );

`ifdef MUL16_SIGNED_EN
    logic neg_q;

    assign mag_a  = in_a[15] ? 16'(~in_a + 16'd1) : in_a;
    assign mag_b  = in_b[15] ? 16'(~in_b + 16'd1) : in_b;
    assign result = neg_q ? 32'(~acc_next + 32'd1) : acc_next;
`else
    assign mag_a  = in_a;
    assign mag_b  = in_b;
    assign result = acc_next;
`endif

    assign zero_op = ZERO_SKIP && ((in_a == '0) || (in_b == '0));
    assign idx     = pp_index(state);
    assign nidx    = idx + 2'd1;

    always_comb begin
        pp_shifted = 32'(pp);
        case (idx)
            2'd0:    pp_shifted = 32'(pp) << SH0;
            2'd1:    pp_shifted = 32'(pp) << SH1;
            2'd2:    pp_shifted = 32'(pp) << SH2;
            default: pp_shifted = 32'(pp) << SH3;
        endcase
    end

    assign acc_next = acc + pp_shifted;

    // Byte muxes are loaded one state ahead so the array output is ready in the PP state that uses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            acc       <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef MUL16_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= mag_a;
                        b_q      <= mag_b;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef MUL16_SIGNED_EN
                        neg_q    <= in_a[15] ^ in_b[15];
`endif
                        if (zero_op) begin
                            out_p     <= '0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            mul_x <= mag_a[7:0];
                            mul_y <= mag_b[7:0];
                            state <= ST_PP0;
                        end
                    end
                end
                ST_PP0, ST_PP1, ST_PP2: begin
                    acc   <= acc_next;
                    mul_x <= sel_byte(a_q, A_HI[nidx]);
                    mul_y <= sel_byte(b_q, B_HI[nidx]);
                    state <= (state == ST_PP0) ? ST_PP1 :
                             (state == ST_PP1) ? ST_PP2 : ST_PP3;
                end
                ST_PP3: begin
                    acc       <= acc_next;
                    out_p     <= result;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Randomized self-checking bench for mul16_seq_ctrl against an arithmetic product model.
// Honours MUL16_SIGNED_EN in the model; a second instance covers ZERO_SKIP=0.
module tb_mul16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;
    logic        busy;

    logic        in_valid_nz = 1'b0;
    logic        in_ready_nz;
    logic [15:0] in_a_nz = '0;
    logic [15:0] in_b_nz = '0;
    logic        out_valid_nz;
    logic [31:0] out_p_nz;
    logic        busy_nz;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul16_seq_ctrl #(.ZERO_SKIP(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    mul16_seq_ctrl #(.ZERO_SKIP(1'b0)) dut_nz (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_nz),
        .in_ready  (in_ready_nz),
        .in_a      (in_a_nz),
        .in_b      (in_b_nz),
        .out_valid (out_valid_nz),
        .out_ready (1'b1),
        .out_p     (out_p_nz),
        .busy      (busy_nz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL16_SIGNED_EN
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
`else
        return 32'(a) * 32'(b);
`endif
    endfunction

    // One transaction on the ZERO_SKIP=1 instance; hold = cycles out_ready stays low in DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        int k;
        int exp_lat;
        logic [31:0] exp_p;
        exp_p   = model_prod(a, b);
        exp_lat = (a == 16'd0 || b == 16'd0) ? 1 : 5;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready", 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        k = 1;
        while (!out_valid && k < 12) begin
            check("busy", 32'(busy), 32'd1);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("out_p", out_p, exp_p);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_p", out_p, exp_p);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        logic [15:0] ra;
        logic [15:0] rb;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", out_p, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        do_op(16'h0003, 16'h0005, 0);
        do_op(16'hFFFF, 16'hFFFF, 0);
        do_op(16'h1234, 16'h5678, 0);
        do_op(16'h0000, 16'h1234, 0);
        do_op(16'h1234, 16'h0000, 2);
        do_op(16'h00FF, 16'hFF00, 3);
`ifdef MUL16_SIGNED_EN
        do_op(16'hFFFF, 16'h0002, 0);
        do_op(16'h8000, 16'h8000, 1);
        do_op(16'h8000, 16'h0001, 0);
`endif

        // Reset while the operation sits in PP2.
        in_valid = 1'b1;
        in_a     = 16'hABCD;
        in_b     = 16'h1357;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ready", 32'(in_ready), 32'd1);
        do_op(16'h0100, 16'h0100, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            do_op(ra, rb, int'($urandom_range(0, 3)));
        end

        // ZERO_SKIP=0 instance: zero operands still take the full sequence.
        for (int n = 0; n < 3; n++) begin
            ra = (n == 0) ? 16'h0000 : 16'($urandom);
            rb = (n == 1) ? 16'h0000 : 16'h1234;
            k = 0;
            while (!in_ready_nz && k < 20) begin
                @(negedge clk);
                k++;
            end
            in_valid_nz = 1'b1;
            in_a_nz     = ra;
            in_b_nz     = rb;
            @(negedge clk);
            in_valid_nz = 1'b0;
            k = 1;
            while (!out_valid_nz && k < 12) begin
                @(negedge clk);
                k++;
            end
            check("nz_latency", 32'(k), 32'd5);
            check("nz_out_p", out_p_nz, model_prod(ra, rb));
            @(negedge clk);
            check("nz_drop", 32'(out_valid_nz), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
